// File: rtl/ahb_arb_pkg.sv
// Shared types, HBURST codes and burst-length helper for the AHB master arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Counted beats for a burst; open-ended INCR returns 0 (released on valid drop instead).
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        logic [4:0] beats;
        case (burst)
            HBURST_SINGLE:                beats = 5'd1;
            HBURST_INCR:                  beats = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            default:                      beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bundle of requester-side and master-port signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready/m_ready carry the accept handshake in each direction.
interface ahb_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*3-1:0]          req_size;
    logic [NUM_REQ*3-1:0]          req_burst;
    logic [NUM_REQ-1:0]            req_busy;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_error;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [NUM_REQ-1:0]            grant;
    // master port side
    logic                          m_valid;
    logic                          m_write;
    logic [ADDR_WIDTH-1:0]         m_addr;
    logic [2:0]                    m_size;
    logic [2:0]                    m_burst;
    logic                          m_busy;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic                          m_sel;
    logic                          m_ready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          m_master_error;
    logic                          m_other_error;

    // Arbiter view: consumes requests and master responses, drives the mux outputs.
    modport master (
        input  req_valid, req_write, req_addr, req_size, req_burst, req_busy, req_wdata,
        input  m_ready, m_rdata, m_master_error, m_other_error,
        output req_ready, req_error, rsp_rdata, grant,
        output m_valid, m_write, m_addr, m_size, m_burst, m_busy, m_wdata, m_sel
    );

    // Environment view: requesters plus the AHB master port model.
    modport slave (
        output req_valid, req_write, req_addr, req_size, req_burst, req_busy, req_wdata,
        output m_ready, m_rdata, m_master_error, m_other_error,
        input  req_ready, req_error, rsp_rdata, grant,
        input  m_valid, m_write, m_addr, m_size, m_burst, m_busy, m_wdata, m_sel
    );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational winner select: first set request bit searching upward from ptr_i (wrapping).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found_o=0 when no request is set.
module ahb_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               found_o,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IW-1:0]      idx_o
);

    // Rotating priority search; the first hit locks out later candidates.
    always_comb begin
        found_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                found_o = 1'b1;
                onehot_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port among NUM_REQ requesters, holding the grant for a whole burst.
// Latency: grant registered 1 cycle after req_valid; command/response muxing is combinational.
// Backpressure: only the owner sees req_ready (=m_ready); others must hold. AHB_ARB_FIXED_PRIO_EN selects fixed priority.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = `AHB_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    ahb_master_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [4:0]         beat_cnt_q, beat_cnt_d;
    logic               incr_q, incr_d;

    logic [IW-1:0]      pick_ptr;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic [2:0]         win_burst;

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Lowest index always wins.
    assign pick_ptr = '0;
`else
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`endif

    ahb_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (pick_ptr),
        .found_o  (pick_found),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    assign win_burst = bus.req_burst[pick_idx*3 +: 3];

    // Owner beat bookkeeping. BUSY beats are never counted.
    logic own_vld, own_busy, beat_acc, err_beat, last_acc, incr_rel, rearb;
    assign own_vld  = bus.req_valid[gidx_q];
    assign own_busy = bus.req_busy[gidx_q];
    assign beat_acc = (state_q == OWN) && own_vld && bus.m_ready && !own_busy;
    assign err_beat = bus.m_ready && (bus.m_master_error || bus.m_other_error);
    assign last_acc = beat_acc && !incr_q && (beat_cnt_q <= 5'd1);
    assign incr_rel = incr_q && !own_vld;
    assign rearb    = (state_q == OWN) && (err_beat || last_acc || incr_rel);

    // State register: abandoning a burst on reset signals nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            beat_cnt_q <= '0;
            incr_q     <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            beat_cnt_q <= beat_cnt_d;
            incr_q     <= incr_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Next state: count beats, and on burst end re-arbitrate in the same cycle (no idle gap).
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        beat_cnt_d = beat_cnt_q;
        incr_d     = incr_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (beat_acc && (beat_cnt_q != 5'd0)) begin
            beat_cnt_d = beat_cnt_q - 5'd1;
        end
        if ((state_q == IDLE) || rearb) begin
            if (pick_found) begin
                state_d    = OWN;
                grant_d    = pick_onehot;
                gidx_d     = pick_idx;
                beat_cnt_d = burst_beats(win_burst);
                incr_d     = (win_burst == HBURST_INCR);
`ifndef AHB_ARB_FIXED_PRIO_EN
                rr_ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
`endif
            end else begin
                state_d    = IDLE;
                grant_d    = '0;
                gidx_d     = '0;
                beat_cnt_d = '0;
                incr_d     = 1'b0;
            end
        end
    end

    // Outputs: owner's command onto m_*, responses routed back to the owner only.
    always_comb begin
        bus.grant     = grant_q;
        bus.m_sel     = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_write   = 1'b0;
        bus.m_addr    = '0;
        bus.m_size    = '0;
        bus.m_burst   = '0;
        bus.m_busy    = 1'b0;
        bus.m_wdata   = '0;
        bus.req_ready = '0;
        bus.req_error = '0;
        bus.rsp_rdata = '0;
        if (state_q == OWN) begin
            bus.m_sel     = 1'b1;
            bus.m_valid   = own_vld;
            bus.m_write   = bus.req_write[gidx_q];
            bus.m_addr    = bus.req_addr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_size    = bus.req_size[gidx_q*3 +: 3];
            bus.m_burst   = bus.req_burst[gidx_q*3 +: 3];
            bus.m_busy    = own_busy;
            bus.m_wdata   = bus.req_wdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
            bus.req_ready = grant_q & {NUM_REQ{bus.m_ready}};
            bus.req_error = grant_q & {NUM_REQ{err_beat}};
            bus.rsp_rdata = bus.m_rdata;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios plus random traffic against a burst-level model.
// Latency: model expects grant one cycle after the arbitration decision.
// Backpressure: m_ready and errors randomised; non-owners must see no ready/error.
module tb_ahb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ahb_master_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests;
    int n_fail;

    // reference model: who owns the port, how many counted beats remain, rotation start
    int m_owner;
    int m_left;
    int m_ptr;
    bit m_open;

    // outputs captured at the last sampling point
    logic [N-1:0] s_grant, s_ready, s_error;
    logic         s_busy, s_sel;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic int pick_winner(input logic [N-1:0] v);
        int start;
`ifdef AHB_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_ptr   = 0;
        m_open  = 1'b0;
    endtask

    task automatic model_grant(input int w);
        logic [2:0] b;
        if (w < 0) begin
            m_owner = -1;
        end else begin
            b       = bus.req_burst[w*3 +: 3];
            m_owner = w;
            m_open  = (b == 3'd1);
            m_left  = beats_of(b);
            m_ptr   = (w + 1) % N;
        end
    endtask

    task automatic model_step();
        bit acc;
        bit fin;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            model_grant(pick_winner(bus.req_valid));
        end else begin
            acc = bus.req_valid[m_owner] && bus.m_ready && !bus.req_busy[m_owner];
            fin = bus.m_ready && (bus.m_master_error || bus.m_other_error);
            if (m_open) begin
                if (!bus.req_valid[m_owner]) fin = 1'b1;
            end else if (acc) begin
                m_left--;
                if (m_left <= 0) fin = 1'b1;
            end
            if (fin) model_grant(pick_winner(bus.req_valid));
        end
    endtask

    task automatic compare_outputs();
        logic [N-1:0] e_g, e_rdy, e_err;
        logic [63:0]  e_cmd, a_cmd, e_rd;
        e_g   = '0;
        e_cmd = '0;
        e_rd  = '0;
        if (m_owner >= 0) begin
            e_g[m_owner] = 1'b1;
            e_cmd = {23'd0, bus.req_valid[m_owner], bus.req_write[m_owner],
                     bus.req_addr[m_owner*AW +: AW], bus.req_size[m_owner*3 +: 3],
                     bus.req_burst[m_owner*3 +: 3], bus.req_busy[m_owner],
                     bus.req_wdata[m_owner*DW +: DW]};
            e_rd  = 64'(bus.m_rdata);
        end
        e_rdy = bus.m_ready ? e_g : '0;
        e_err = (bus.m_ready && (bus.m_master_error || bus.m_other_error)) ? e_g : '0;
        a_cmd = {23'd0, bus.m_valid, bus.m_write, bus.m_addr, bus.m_size, bus.m_burst,
                 bus.m_busy, bus.m_wdata};
        s_grant = bus.grant;
        s_ready = bus.req_ready;
        s_error = bus.req_error;
        s_busy  = bus.m_busy;
        s_sel   = bus.m_sel;
        check("grant",     64'(bus.grant),     64'(e_g));
        check("m_sel",     64'(bus.m_sel),     64'(m_owner >= 0));
        check("m_cmd",     a_cmd,              e_cmd);
        check("req_ready", 64'(bus.req_ready), 64'(e_rdy));
        check("req_error", 64'(bus.req_error), 64'(e_err));
        check("rsp_rdata", 64'(bus.rsp_rdata), e_rd);
    endtask

    // one clock: compare on the falling edge, advance the model on the rising edge
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [2:0] b);
        bus.req_valid[i]          = v;
        bus.req_burst[i*3 +: 3]   = b;
        bus.req_busy[i]           = 1'b0;
        bus.req_write[i]          = 1'($urandom);
        bus.req_addr[i*AW +: AW]  = AW'($urandom);
        bus.req_size[i*3 +: 3]    = 3'($urandom);
        bus.req_wdata[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic clear_inputs();
        bus.req_valid      = '0;
        bus.req_write      = '0;
        bus.req_addr       = '0;
        bus.req_size       = '0;
        bus.req_burst      = '0;
        bus.req_busy       = '0;
        bus.req_wdata      = '0;
        bus.m_ready        = 1'b0;
        bus.m_rdata        = '0;
        bus.m_master_error = 1'b0;
        bus.m_other_error  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        model_reset();
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int exp2 [9];
        int exp3 [6];
        int held, beats, busys;
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;

        // reset state
        cycle();
        check("rst_grant", 64'(s_grant), 64'd0);
        check("rst_sel",   64'(s_sel),   64'd0);
        rstn = 1'b1;
        cycle();
        check("idle_grant", 64'(s_grant), 64'd0);

        // single requester: grant one cycle after req_valid
        set_req(2, 1'b1, 3'b000);
        cycle();
        check("t1_pre", 64'(s_grant), 64'd0);
        cycle();
        check("t1_grant", 64'(s_grant), 64'b0100);
        check("t1_sel",   64'(s_sel),   64'd1);

        // two INCR4 requesters
        do_reset();
`ifdef AHB_ARB_FIXED_PRIO_EN
        exp2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
`else
        exp2 = '{0, 1, 1, 1, 1, 4, 4, 4, 4};
`endif
        set_req(0, 1'b1, 3'b011);
        set_req(2, 1'b1, 3'b011);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            check($sformatf("t2_grant%0d", k), 64'(s_grant), 64'(exp2[k]));
        end

        // fairness with continuous SINGLEs
        do_reset();
`ifdef AHB_ARB_FIXED_PRIO_EN
        exp3 = '{0, 1, 1, 1, 1, 1};
`else
        exp3 = '{0, 1, 2, 4, 8, 1};
`endif
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'b000);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check($sformatf("t3_grant%0d", k), 64'(s_grant), 64'(exp3[k]));
        end

        // INCR8 with two BUSY beats
        do_reset();
        set_req(1, 1'b1, 3'b101);
        bus.m_ready = 1'b1;
        cycle();
        held = 0; beats = 0; busys = 0;
        for (int k = 0; k < 10; k++) begin
            bus.req_busy[1] = (k == 2 || k == 5);
            cycle();
            if (s_grant == 4'b0010) held++;
            if (s_ready[1] && !s_busy) beats++;
            if (s_busy) busys++;
        end
        bus.req_busy[1] = 1'b0;
        check("t4_held",  64'(held),  64'd10);
        check("t4_beats", 64'(beats), 64'd8);
        check("t4_busy",  64'(busys), 64'd2);

        // INCR4 truncated by an error on beat 2
        do_reset();
        set_req(3, 1'b1, 3'b011);
        bus.m_ready = 1'b1;
        cycle();
        cycle();
        check("t5_err_beat1", 64'(s_error), 64'd0);
        bus.m_other_error = 1'b1;
        set_req(1, 1'b1, 3'b000);
        cycle();
        check("t5_err_pulse", 64'(s_error), 64'b1000);
        check("t5_err_ready", 64'(s_ready), 64'b1000);
        bus.m_other_error = 1'b0;
        cycle();
        check("t5_regrant", 64'(s_grant), 64'b0010);

        // reset in the middle of an INCR16
        do_reset();
        set_req(2, 1'b1, 3'b111);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("t6_grant", 64'(bus.grant),     64'd0);
        check("t6_sel",   64'(bus.m_sel),     64'd0);
        check("t6_valid", 64'(bus.m_valid),   64'd0);
        check("t6_ready", 64'(bus.req_ready), 64'd0);
        cycle();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'b000);
        rstn = 1'b1;
        cycle();
        cycle();
        check("t6_rr_restart", 64'(s_grant), 64'b0001);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rstn = 1'b1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) set_req(i, $urandom_range(2) != 0, 3'($urandom));
                bus.req_busy[i]           = ($urandom_range(7) == 0);
                bus.req_wdata[i*DW +: DW] = DW'($urandom);
            end
            bus.m_ready        = ($urandom_range(3) != 0);
            bus.m_rdata        = DW'($urandom);
            bus.m_master_error = ($urandom_range(40) == 0);
            bus.m_other_error  = ($urandom_range(40) == 0);
            if ($urandom_range(499) == 0) begin
                rstn = 1'b0;
                model_reset();
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
